// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the per-source writeback buffer entry.
// Widths are the largest the arbiter supports; the arbiter's own width parameters
// default to these values and must not exceed them.
package wb_pkg;
  localparam int WB_PREG_W = 6;
  localparam int WB_DATA_W = 64;
  localparam int WB_ROB_W  = 6;
  typedef struct packed {
    logic                 vld;
    logic [WB_PREG_W-1:0] preg;
    logic [WB_DATA_W-1:0] data;
    logic [WB_ROB_W-1:0]  robidx;
  } wb_entry_t;
endpackage

// File: rtl/wb_rr_pick2.sv
// wb_rr_pick2: combinational round-robin picker granting up to two requesters.
// Ports: i_vld   request vector
//        i_ptr   index where the scan starts (wraps modulo N)
//        o_gnt0  one-hot grant for the first valid requester found
//        o_gnt1  one-hot grant for the second valid requester found
//        o_idx0/o_idx1 encoded indices of the two grants (0 when absent)
//        o_any0/o_any1 the corresponding grant exists
module wb_rr_pick2 #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vld,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt0,
  output logic [N-1:0]  o_gnt1,
  output logic [IW-1:0] o_idx0,
  output logic [IW-1:0] o_idx1,
  output logic          o_any0,
  output logic          o_any1
);
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction
  always_comb begin
    o_gnt0 = '0;
    o_gnt1 = '0;
    o_idx0 = '0;
    o_idx1 = '0;
    o_any0 = 1'b0;
    o_any1 = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_vld[wrap(int'(i_ptr) + k)]) begin
        if (!o_any0) begin
          o_gnt0[wrap(int'(i_ptr) + k)] = 1'b1;
          o_idx0 = wrap(int'(i_ptr) + k);
          o_any0 = 1'b1;
        end else if (!o_any1) begin
          o_gnt1[wrap(int'(i_ptr) + k)] = 1'b1;
          o_idx1 = wrap(int'(i_ptr) + k);
          o_any1 = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/pregfile_wb_arbiter.sv
// pregfile_wb_arbiter: buffers one result per execution source and grants up to
// two per cycle round-robin onto the register-file write ports and ROB completion ports.
// Ports: clock, reset (sync, active-high), flush (drops all buffered results)
//        src_valid/src_ready/src_preg/src_data/src_robidx  per-source result inputs
//        wren*/waddr*/wdata*       register-file write ports 0 and 1
//        cmpl*_valid/cmpl*_robidx  ROB completion ports 0 and 1
module pregfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PREG_W  = WB_PREG_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int ROB_W   = WB_ROB_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*PREG_W-1:0] src_preg,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*ROB_W-1:0]  src_robidx,
  output logic                      wren0,
  output logic                      wren1,
  output logic [PREG_W-1:0]         waddr0,
  output logic [PREG_W-1:0]         waddr1,
  output logic [DATA_W-1:0]         wdata0,
  output logic [DATA_W-1:0]         wdata1,
  output logic                      cmpl0_valid,
  output logic                      cmpl1_valid,
  output logic [ROB_W-1:0]          cmpl0_robidx,
  output logic [ROB_W-1:0]          cmpl1_robidx
);
  localparam int IW = $clog2(NUM_SRC);
  wb_entry_t          r_buf [NUM_SRC];
  logic [IW-1:0]      r_rr_ptr;
  logic [NUM_SRC-1:0] w_vld;
  logic [NUM_SRC-1:0] w_gnt0;
  logic [NUM_SRC-1:0] w_gnt1;
  logic [IW-1:0]      w_idx0;
  logic [IW-1:0]      w_idx1;
  logic               w_any0;
  logic               w_any1;
  logic               w_c0;
  logic               w_c1;
  logic [IW-1:0]      w_last;
  logic [IW-1:0]      w_next;
  wb_entry_t          w_e0;
  wb_entry_t          w_e1;
  always_comb begin
    w_vld = '0;
    for (int i = 0; i < NUM_SRC; i++) w_vld[i] = r_buf[i].vld;
  end
  wb_rr_pick2 #(.N(NUM_SRC), .IW(IW)) u_pick (
    .i_vld  (w_vld),
    .i_ptr  (r_rr_ptr),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1),
    .o_idx0 (w_idx0),
    .o_idx1 (w_idx1),
    .o_any0 (w_any0),
    .o_any1 (w_any1)
  );
  assign w_e0 = r_buf[w_idx0];
  assign w_e1 = r_buf[w_idx1];
  assign w_c0 = w_any0 && !flush;
  assign w_c1 = w_any1 && !flush;
  // A drained entry can take a new result in the same cycle, giving full-rate pass-through.
  assign src_ready = (reset || flush) ? '0 : (~w_vld | w_gnt0 | w_gnt1);
  assign w_last = w_any1 ? w_idx1 : w_idx0;
  assign w_next = (w_last == IW'(NUM_SRC - 1)) ? '0 : w_last + 1'b1;
  // preg 0 is x0: it still completes to the ROB but never writes the register file.
  assign cmpl0_valid  = w_c0;
  assign cmpl1_valid  = w_c1;
  assign wren0        = w_c0 && (w_e0.preg != '0);
  assign wren1        = w_c1 && (w_e1.preg != '0);
  assign waddr0       = w_c0 ? w_e0.preg[PREG_W-1:0]  : '0;
  assign waddr1       = w_c1 ? w_e1.preg[PREG_W-1:0]  : '0;
  assign wdata0       = w_c0 ? w_e0.data[DATA_W-1:0]  : '0;
  assign wdata1       = w_c1 ? w_e1.data[DATA_W-1:0]  : '0;
  assign cmpl0_robidx = w_c0 ? w_e0.robidx[ROB_W-1:0] : '0;
  assign cmpl1_robidx = w_c1 ? w_e1.robidx[ROB_W-1:0] : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) r_buf[i].vld <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (flush) r_buf[i].vld <= 1'b0;
        else if (src_valid[i] && src_ready[i]) begin
          r_buf[i].vld    <= 1'b1;
          r_buf[i].preg   <= WB_PREG_W'(src_preg[i*PREG_W +: PREG_W]);
          r_buf[i].data   <= WB_DATA_W'(src_data[i*DATA_W +: DATA_W]);
          r_buf[i].robidx <= WB_ROB_W'(src_robidx[i*ROB_W +: ROB_W]);
        end else if (w_gnt0[i] || w_gnt1[i]) r_buf[i].vld <= 1'b0;
      end
      if (!flush && w_any0) r_rr_ptr <= w_next;
    end
  end
endmodule

// File: tb/tb_pregfile_wb_arbiter.sv
// tb_pregfile_wb_arbiter: directed self-checking bench for pregfile_wb_arbiter (4 sources).
module tb_pregfile_wb_arbiter;
  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic [23:0]  src_preg;
  logic [255:0] src_data;
  logic [23:0]  src_robidx;
  logic         wren0, wren1, cmpl0_valid, cmpl1_valid;
  logic [5:0]   waddr0, waddr1, cmpl0_robidx, cmpl1_robidx;
  logic [63:0]  wdata0, wdata1;
  int checks = 0;
  int errors = 0;
  pregfile_wb_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_preg     (src_preg),
    .src_data     (src_data),
    .src_robidx   (src_robidx),
    .wren0        (wren0),
    .wren1        (wren1),
    .waddr0       (waddr0),
    .waddr1       (waddr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .cmpl0_valid  (cmpl0_valid),
    .cmpl1_valid  (cmpl1_valid),
    .cmpl0_robidx (cmpl0_robidx),
    .cmpl1_robidx (cmpl1_robidx)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic put(input int i, input logic [5:0] p, input logic [63:0] d, input logic [5:0] r);
    src_valid[i]         = 1'b1;
    src_preg[i*6 +: 6]   = p;
    src_data[i*64 +: 64] = d;
    src_robidx[i*6 +: 6] = r;
  endtask
  // Two grants must never target the same nonzero preg.
  always @(negedge clock)
    if (!reset && wren0 && wren1) chk("addr_conflict", 64'(waddr0 != waddr1), 64'd1);
  int pres [5][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{8, 9, 6, 7}, '{8, 9, 10, 11}, '{12, 13, 10, 11}};
  int er0  [7]    = '{0, 0, 2, 4, 6, 8, 10};
  int er1  [7]    = '{0, 1, 3, 5, 7, 9, 11};
  int erdy [7]    = '{15, 3, 12, 3, 12, 3, 15};
  initial begin
    reset = 1'b1; flush = 1'b0; src_valid = '0; src_preg = '0; src_data = '0; src_robidx = '0;
    tick();
    tick();
    #1;
    chk("rst_ready", src_ready, 0);
    chk("rst_wren0", wren0, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", src_ready, 4'hF);
    chk("post_rst_ptr", dut.r_rr_ptr, 0);
    chk("post_rst_cmpl0", cmpl0_valid, 0);
    chk("post_rst_wren1", wren1, 0);
    // single result from source 2
    put(2, 6'd5, 64'hDEAD, 6'd9);
    tick();
    src_valid = '0;
    #1;
    chk("single_wren0", wren0, 1);
    chk("single_waddr0", waddr0, 5);
    chk("single_wdata0", wdata0, 64'hDEAD);
    chk("single_cmpl0", cmpl0_valid, 1);
    chk("single_rob0", cmpl0_robidx, 9);
    chk("single_cmpl1", cmpl1_valid, 0);
    chk("single_wren1", wren1, 0);
    chk("single_waddr1", waddr1, 0);
    tick();
    #1;
    chk("single_ptr", dut.r_rr_ptr, 3);
    chk("single_drained", cmpl0_valid, 0);
    // x0 destination
    put(0, 6'd0, 64'h1234, 6'd4);
    tick();
    src_valid = '0;
    #1;
    chk("x0_cmpl0", cmpl0_valid, 1);
    chk("x0_rob0", cmpl0_robidx, 4);
    chk("x0_wren0", wren0, 0);
    tick();
    #1;
    chk("x0_ptr", dut.r_rr_ptr, 1);
    // full load fairness from rr_ptr 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("fl_ptr0", dut.r_rr_ptr, 0);
    for (int c = 0; c < 7; c++) begin
      src_valid = '0;
      if (c < 5) for (int i = 0; i < 4; i++) put(i, 6'(10 + i), 64'(pres[c][i] * 'h111), 6'(pres[c][i]));
      #1;
      chk($sformatf("fl_ready_c%0d", c), src_ready, 64'(erdy[c]));
      if (c > 0) begin
        chk($sformatf("fl_rob0_c%0d", c), cmpl0_robidx, 64'(er0[c]));
        chk($sformatf("fl_rob1_c%0d", c), cmpl1_robidx, 64'(er1[c]));
        chk($sformatf("fl_2wr_c%0d", c), {wren0, wren1}, 2'b11);
        chk($sformatf("fl_waddr0_c%0d", c), waddr0, (c % 2) ? 10 : 12);
        chk($sformatf("fl_wdata1_c%0d", c), wdata1, 64'(er1[c] * 'h111));
      end
      tick();
    end
    chk("fl_end_ptr", dut.r_rr_ptr, 0);
    chk("fl_end_idle", cmpl0_valid, 0);
    // backpressure on source 0
    src_valid = '0;
    for (int i = 0; i < 4; i++) put(i, 6'(10 + i), 64'd0, 6'(20 + i));
    tick();
    src_valid = '0;
    put(0, 6'd10, 64'd0, 6'd24);
    #1;
    chk("bp_rdy0_b1", src_ready[0], 1);
    chk("bp_rob0_b1", cmpl0_robidx, 20);
    chk("bp_rob1_b1", cmpl1_robidx, 21);
    tick();
    put(0, 6'd10, 64'd0, 6'd28);
    #1;
    chk("bp_rdy0_b2", src_ready[0], 0);
    chk("bp_rob0_b2", cmpl0_robidx, 22);
    chk("bp_rob1_b2", cmpl1_robidx, 23);
    tick();
    #1;
    chk("bp_rdy0_b3", src_ready[0], 1);
    chk("bp_rob0_b3", cmpl0_robidx, 24);
    chk("bp_cmpl1_b3", cmpl1_valid, 0);
    tick();
    src_valid = '0;
    #1;
    chk("bp_cmpl0_b4", cmpl0_valid, 1);
    chk("bp_rob0_b4", cmpl0_robidx, 28);
    chk("bp_cmpl1_b4", cmpl1_valid, 0);
    tick();
    #1;
    chk("bp_nodup", cmpl0_valid, 0);
    chk("bp_ptr", dut.r_rr_ptr, 1);
    // flush with three buffers full
    put(1, 6'd11, 64'd0, 6'd30);
    put(2, 6'd12, 64'd0, 6'd31);
    put(3, 6'd13, 64'd0, 6'd32);
    tick();
    src_valid = '0;
    put(0, 6'd1, 64'd0, 6'd33);
    flush = 1'b1;
    #1;
    chk("fls_ready", src_ready, 0);
    chk("fls_wren", {wren0, wren1}, 0);
    chk("fls_cmpl", {cmpl0_valid, cmpl1_valid}, 0);
    tick();
    flush = 1'b0;
    src_valid = '0;
    #1;
    chk("fls_after_ready", src_ready, 4'hF);
    chk("fls_after_cmpl", {cmpl0_valid, cmpl1_valid}, 0);
    chk("fls_after_wren", {wren0, wren1}, 0);
    chk("fls_ptr_kept", dut.r_rr_ptr, 1);
    // reset in the middle of full load
    for (int i = 0; i < 4; i++) put(i, 6'(10 + i), 64'd0, 6'(40 + i));
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) put(i, 6'(10 + i), 64'd0, 6'(44 + i));
    tick();
    reset = 1'b0;
    src_valid = '0;
    put(1, 6'd11, 64'd0, 6'd50);
    put(3, 6'd13, 64'd0, 6'd51);
    #1;
    chk("mrst_cmpl", {cmpl0_valid, cmpl1_valid}, 0);
    chk("mrst_wren", {wren0, wren1}, 0);
    chk("mrst_ptr", dut.r_rr_ptr, 0);
    chk("mrst_ready", src_ready, 4'hF);
    tick();
    src_valid = '0;
    #1;
    chk("mrst_rob0", cmpl0_robidx, 50);
    chk("mrst_rob1", cmpl1_robidx, 51);
    chk("mrst_wren1", wren1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
